// File: rtl/uart_frame_pkg.sv
// Shared constants, FSM state encoding and width helper for the UART frame parser.
package uart_frame_pkg;

    localparam logic [7:0] HDR0 = 8'h55;
    localparam logic [7:0] HDR1 = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_CMD,
        ST_LEN,
        ST_PAY,
        ST_SUM,
        ST_HOLD
    } state_t;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/frame_payload_ram.sv
// Payload store: one write port, one registered read port whose output is forced
// to zero when the caller marks the address as outside the held frame.
module frame_payload_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    input  logic          i_rd_ok,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= i_rd_ok ? r_mem[i_raddr] : '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles 0x55 0xAA CMD LEN PAYLOAD SUM frames from the UART byte stream, holds
// one good frame until acknowledged, and reports checksum/length/timeout errors.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 50000,
    parameter int LEN_W       = len_w(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RecDone,
    input  logic [7:0]       RecData,
    output logic             FrmValid,
    output logic [7:0]       FrmCmd,
    output logic [LEN_W-1:0] FrmLen,
    input  logic             FrmAck,
    input  logic [LEN_W-1:0] RdAddr,
    output logic [7:0]       RdData,
    output logic             ErrSum,
    output logic             ErrLen,
    output logic             ErrTmo,
    output logic [7:0]       DropCnt
);

    localparam int             IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int             TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_sum;
    logic [7:0]       r_cmd;
    logic [LEN_W-1:0] r_len;
    logic [IW-1:0]    r_idx;
    logic [TW-1:0]    r_tmo;
    logic             r_frm_valid;
    logic [7:0]       r_frm_cmd;
    logic [LEN_W-1:0] r_frm_len;
    logic             r_err_sum;
    logic             r_err_len;
    logic             r_err_tmo;
    logic [7:0]       r_drop;

    logic             w_in_frame;
    logic             w_tmo_hit;
    logic             w_pay_last;
    logic             w_err_sum;
    logic             w_err_len;
    logic             w_accept;
    logic             w_release;
    logic             w_ram_we;
    logic             w_drop;
    logic             w_rd_ok;

    assign w_in_frame = (r_state != ST_IDLE) && (r_state != ST_HOLD);
    // A byte arriving on the terminal count cycle keeps the frame alive.
    assign w_tmo_hit  = w_in_frame && !RecDone && (r_tmo == TMO_LAST);
    assign w_pay_last = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));
    assign w_rd_ok    = (RdAddr < r_frm_len);

    always_comb begin
        w_state_nxt = r_state;
        w_err_sum   = 1'b0;
        w_err_len   = 1'b0;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        w_ram_we    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (RecDone && RecData == HDR0) w_state_nxt = ST_HDR1;
            end
            ST_HDR1: begin
                if (RecDone) begin
                    if (RecData == HDR1)      w_state_nxt = ST_CMD;
                    else if (RecData == HDR0) w_state_nxt = ST_HDR1;
                    else                      w_state_nxt = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (RecDone) w_state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (RecDone) begin
                    if (RecData > MAX_LEN_B) begin
                        w_err_len   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (RecData == 8'h00) begin
                        w_state_nxt = ST_SUM;
                    end else begin
                        w_state_nxt = ST_PAY;
                    end
                end
            end
            ST_PAY: begin
                if (RecDone) begin
                    w_ram_we = 1'b1;
                    if (w_pay_last) w_state_nxt = ST_SUM;
                end
            end
            ST_SUM: begin
                if (RecDone) begin
                    if (RecData == r_sum) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_err_sum   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                w_drop = RecDone;
                if (FrmAck) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_tmo_hit) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sum       <= '0;
            r_cmd       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_tmo       <= '0;
            r_frm_valid <= 1'b0;
            r_frm_cmd   <= '0;
            r_frm_len   <= '0;
            r_err_sum   <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_tmo   <= 1'b0;
            r_drop      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_err_sum <= w_err_sum;
            r_err_len <= w_err_len;
            r_err_tmo <= w_tmo_hit;

            if (!w_in_frame || RecDone || w_tmo_hit) r_tmo <= '0;
            else                                     r_tmo <= r_tmo + 1'b1;

            if (RecDone) begin
                case (r_state)
                    ST_CMD: begin
                        r_cmd <= RecData;
                        r_sum <= RecData;
                    end
                    ST_LEN: begin
                        r_len <= RecData[LEN_W-1:0];
                        r_idx <= '0;
                        r_sum <= r_sum + RecData;
                    end
                    ST_PAY: begin
                        r_idx <= r_idx + 1'b1;
                        r_sum <= r_sum + RecData;
                    end
                    default: ;
                endcase
            end

            if (w_accept) begin
                r_frm_valid <= 1'b1;
                r_frm_cmd   <= r_cmd;
                r_frm_len   <= r_len;
            end else if (w_release) begin
                r_frm_valid <= 1'b0;
            end

            if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
        end
    end

    frame_payload_ram #(
        .DEPTH (MAX_LEN),
        .AW    (IW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_ram_we),
        .i_waddr (r_idx),
        .i_wdata (RecData),
        .i_raddr (RdAddr[IW-1:0]),
        .i_rd_ok (w_rd_ok),
        .o_rdata (RdData)
    );

    assign FrmValid = r_frm_valid;
    assign FrmCmd   = r_frm_cmd;
    assign FrmLen   = r_frm_len;
    assign ErrSum   = r_err_sum;
    assign ErrLen   = r_err_len;
    assign ErrTmo   = r_err_tmo;
    assign DropCnt  = r_drop;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench: stimulus queues expected frame/error events, a negedge
// monitor pops and compares them as the parser reports them.
module tb_uart_frame_parser;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 40;
    localparam int LEN_W   = 5;

    typedef enum int {EV_FRAME, EV_SUM, EV_LEN, EV_TMO} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] cmd;
        logic [4:0] len;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             RecDone = 1'b0;
    logic [7:0]       RecData = 8'h00;
    logic             FrmValid;
    logic [7:0]       FrmCmd;
    logic [LEN_W-1:0] FrmLen;
    logic             FrmAck = 1'b0;
    logic [LEN_W-1:0] RdAddr = '0;
    logic [7:0]       RdData;
    logic             ErrSum;
    logic             ErrLen;
    logic             ErrTmo;
    logic [7:0]       DropCnt;

    int  errors = 0;
    int  checks = 0;
    ev_t exp_q[$];
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    uart_frame_parser #(
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .RecDone  (RecDone),
        .RecData  (RecData),
        .FrmValid (FrmValid),
        .FrmCmd   (FrmCmd),
        .FrmLen   (FrmLen),
        .FrmAck   (FrmAck),
        .RdAddr   (RdAddr),
        .RdData   (RdData),
        .ErrSum   (ErrSum),
        .ErrLen   (ErrLen),
        .ErrTmo   (ErrTmo),
        .DropCnt  (DropCnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [7:0] c, input logic [4:0] l);
        ev_t e;
        e.kind = k;
        e.cmd  = c;
        e.len  = l;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none", k);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            if (e.kind == EV_FRAME) begin
                chk("frame_cmd", FrmCmd, e.cmd);
                chk("frame_len", FrmLen, e.len);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (FrmValid && !prev_valid) sb_pop(EV_FRAME);
            if (ErrSum) sb_pop(EV_SUM);
            if (ErrLen) sb_pop(EV_LEN);
            if (ErrTmo) sb_pop(EV_TMO);
            prev_valid = FrmValid;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        RecDone = 1'b1;
        RecData = b;
        @(posedge clk); #1;
        RecDone = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_seq(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i], 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!FrmValid && n < 50) begin
            cycles(1);
            n++;
        end
        if (!FrmValid) chk({name, "_valid_timeout"}, 32'(FrmValid), 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            cycles(1);
            n++;
        end
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic read_chk(input logic [4:0] a, input logic [7:0] exp);
        RdAddr = a;
        cycles(1);
        chk($sformatf("rd_%0d", a), RdData, exp);
    endtask

    task automatic ack();
        FrmAck = 1'b1;
        cycles(1);
        FrmAck = 1'b0;
    endtask

    initial begin
        logic [7:0] big[$];
        #1;
        cycles(3);
        chk("rst_valid", FrmValid, 1'b0);
        chk("rst_cmd", FrmCmd, 8'h00);
        chk("rst_len", FrmLen, 5'd0);
        chk("rst_rddata", RdData, 8'h00);
        chk("rst_errs", {ErrSum, ErrLen, ErrTmo}, 3'b000);
        chk("rst_drop", DropCnt, 8'h00);
        rst = 1'b0;
        cycles(2);

        expect_ev(EV_FRAME, 8'h03, 5'd2);
        send_seq('{8'h55, 8'hAA, 8'h03, 8'h02, 8'h11, 8'h22, 8'h38});
        wait_valid("good1");
        read_chk(5'd0, 8'h11);
        read_chk(5'd1, 8'h22);
        read_chk(5'd2, 8'h00);
        read_chk(5'd15, 8'h00);
        ack();
        chk("ack_valid", FrmValid, 1'b0);
        chk("ack_cmd_hold", FrmCmd, 8'h03);
        chk("ack_len_hold", FrmLen, 5'd2);
        drain("good1");

        expect_ev(EV_SUM, 8'h00, 5'd0);
        send_seq('{8'h55, 8'hAA, 8'h03, 8'h02, 8'h11, 8'h22, 8'h39});
        drain("badsum");
        chk("badsum_valid", FrmValid, 1'b0);
        expect_ev(EV_FRAME, 8'h05, 5'd1);
        send_seq('{8'h55, 8'hAA, 8'h05, 8'h01, 8'hA0, 8'hA6});
        wait_valid("good2");
        read_chk(5'd0, 8'hA0);
        read_chk(5'd1, 8'h00);
        ack();
        drain("good2");

        expect_ev(EV_LEN, 8'h00, 5'd0);
        send_seq('{8'h55, 8'hAA, 8'h01, 8'h11});
        expect_ev(EV_FRAME, 8'h01, 5'd0);
        send_seq('{8'h55, 8'hAA, 8'h01, 8'h00, 8'h01});
        wait_valid("len0");
        read_chk(5'd0, 8'h00);
        ack();
        drain("len0");

        send_byte(8'h12, 3);
        expect_ev(EV_FRAME, 8'h07, 5'd0);
        send_seq('{8'h55, 8'h55, 8'hAA, 8'h07});
        ack();
        send_seq('{8'h00, 8'h07});
        wait_valid("resync");
        ack();
        drain("resync");

        // Full-length frame: payload 01..10, sum = 20+10+88 = B8.
        big = '{8'h55, 8'hAA, 8'h20, 8'h10};
        for (int i = 1; i <= 16; i++) big.push_back(8'(i));
        big.push_back(8'hB8);
        expect_ev(EV_FRAME, 8'h20, 5'd16);
        send_seq(big);
        wait_valid("maxlen");
        read_chk(5'd15, 8'h10);
        read_chk(5'd16, 8'h00);
        for (int i = 0; i < 300; i++) send_byte(8'(i), 0);
        chk("drop_sat", DropCnt, 8'hFF);
        chk("hold_valid", FrmValid, 1'b1);
        chk("hold_cmd", FrmCmd, 8'h20);
        chk("hold_len", FrmLen, 5'd16);
        read_chk(5'd3, 8'h04);
        read_chk(5'd0, 8'h01);
        RecDone = 1'b1;
        RecData = 8'h55;
        FrmAck  = 1'b1;
        cycles(1);
        RecDone = 1'b0;
        FrmAck  = 1'b0;
        chk("ack_drop_valid", FrmValid, 1'b0);
        chk("ack_drop_cnt", DropCnt, 8'hFF);
        drain("maxlen");

        expect_ev(EV_TMO, 8'h00, 5'd0);
        send_seq('{8'h55, 8'hAA, 8'h03});
        cycles(TMO + 5);
        drain("tmo");
        expect_ev(EV_FRAME, 8'h09, 5'd0);
        send_byte(8'h55, 1);
        send_byte(8'hAA, TMO - 1);
        send_seq('{8'h09, 8'h00, 8'h09});
        wait_valid("tmo_edge");
        ack();
        drain("tmo_edge");

        send_seq('{8'h55, 8'hAA, 8'h03, 8'h02, 8'h11});
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(1);
        chk("midrst_valid", FrmValid, 1'b0);
        chk("midrst_drop", DropCnt, 8'h00);
        expect_ev(EV_FRAME, 8'h42, 5'd1);
        send_seq('{8'h55, 8'hAA, 8'h42, 8'h01, 8'h5A, 8'h9D});
        wait_valid("post_rst");
        read_chk(5'd0, 8'h5A);
        ack();
        drain("post_rst");

        cycles(TMO + 10);
        chk("final_pending", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
